fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the control unit. Owns the 10-bit program counter and reads 16-bit instruction words from instruction memory over a req/ack handshake. Keeps one prefetched word behind the current one and presents `instruction`, zero-extended `imm` and `pc` to the CU with a valid/ready handshake. Takes the CU's `branch`/target back to redirect fetch and squash wrong-path words.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_buf.sv | 79 +++++++
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_pkg                                                                    |
// | Shared widths, opcode field bounds and fetch state encoding for the core.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package cpu_pkg;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 16;
    localparam int IMM_W   = 9;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SQUASH = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_buf                                                                  |
// | Two-entry instruction queue: IR (presented word) and PB (prefetched word). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_buf
    import cpu_pkg::*;
#(
    parameter int DATA_W = INSTR_W,
    parameter int TAG_W  = PC_W
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic [TAG_W-1:0]  push_pc,
    input  logic              pop,
    output logic              ir_valid,
    output logic [DATA_W-1:0] ir_data,
    output logic [TAG_W-1:0]  ir_pc,
    output logic              pb_valid,
    output logic              pb_valid_nxt
);

    logic              r_ir_valid;
    logic [DATA_W-1:0] r_ir_data;
    logic [TAG_W-1:0]  r_ir_pc;
    logic              r_pb_valid;
    logic [DATA_W-1:0] r_pb_data;
    logic [TAG_W-1:0]  r_pb_pc;

    // A push never coincides with a pop while PB is full: the fetcher does
    // not request while PB holds a word.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_ir_valid <= 1'b0;
            r_ir_data  <= '0;
            r_ir_pc    <= '0;
            r_pb_valid <= 1'b0;
            r_pb_data  <= '0;
            r_pb_pc    <= '0;
        end else if (flush) begin
            r_ir_valid <= 1'b0;
            r_pb_valid <= 1'b0;
        end else if (pop) begin
            if (r_pb_valid) begin
                r_ir_data  <= r_pb_data;
                r_ir_pc    <= r_pb_pc;
                r_pb_valid <= 1'b0;
            end else if (push) begin
                r_ir_data  <= push_data;
                r_ir_pc    <= push_pc;
            end else begin
                r_ir_valid <= 1'b0;
            end
        end else if (push) begin
            if (!r_ir_valid) begin
                r_ir_valid <= 1'b1;
                r_ir_data  <= push_data;
                r_ir_pc    <= push_pc;
            end else begin
                r_pb_valid <= 1'b1;
                r_pb_data  <= push_data;
                r_pb_pc    <= push_pc;
            end
        end
    end

    assign pb_valid_nxt = ~flush & ((r_pb_valid & ~pop) | (push & ~pop & r_ir_valid));

    assign ir_valid = r_ir_valid;
    assign ir_data  = r_ir_data;
    assign ir_pc    = r_ir_pc;
    assign pb_valid = r_pb_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_unit                                                                 |
// | Instruction fetch: owns the PC, fetches over req/ack, redirects on branch. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_unit #(
    parameter int                     PC_W     = cpu_pkg::PC_W,
    parameter int                     INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [PC_W-1:0]        RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_b,
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    input  logic               cu_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic [15:0]        imm,
    output logic [PC_W-1:0]    pc,
    input  logic               branch,
    input  logic [PC_W-1:0]    branch_target
);
    import cpu_pkg::*;

    fetch_state_t    r_state, w_state_nxt;
    logic [PC_W-1:0] r_fa, w_fa_nxt;
    logic [PC_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic            r_mem_req, w_mem_req_nxt;

    logic            w_ack, w_cons, w_take_branch, w_push;
    logic            w_ir_valid, w_pb_valid, w_pb_valid_nxt;

    assign w_ack         = r_mem_req & mem_ack;
    assign w_cons        = w_ir_valid & cu_ready;
    assign w_take_branch = w_cons & branch;
    assign w_push        = w_ack & (r_state == RUN) & ~w_take_branch;

    always_comb begin
        w_state_nxt    = r_state;
        w_fa_nxt       = r_fa;
        w_mem_req_nxt  = r_mem_req;
        w_mem_addr_nxt = r_mem_addr;
        case (r_state)
            IDLE: begin
                w_state_nxt    = RUN;
                w_mem_req_nxt  = 1'b1;
                w_mem_addr_nxt = r_fa;
            end
            RUN: begin
                if (w_take_branch) begin
                    w_fa_nxt = branch_target;
                end else if (w_ack) begin
                    w_fa_nxt = r_fa + PC_W'(1);
                end
                // An outstanding request must complete at its own address;
                // a redirect during it has to throw that word away later.
                if (r_mem_req && !mem_ack) begin
                    if (w_take_branch) begin
                        w_state_nxt = SQUASH;
                    end
                end else begin
                    w_mem_req_nxt  = ~w_pb_valid_nxt;
                    w_mem_addr_nxt = w_fa_nxt;
                end
            end
            SQUASH: begin
                if (w_ack) begin
                    w_state_nxt    = RUN;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_addr_nxt = r_fa;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_state    <= IDLE;
            r_fa       <= RESET_PC;
            r_mem_req  <= 1'b0;
            r_mem_addr <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fa       <= w_fa_nxt;
            r_mem_req  <= w_mem_req_nxt;
            r_mem_addr <= w_mem_addr_nxt;
        end
    end

    fetch_buf #(
        .DATA_W (INSTR_W),
        .TAG_W  (PC_W)
    ) u_fetch_buf (
        .clk          (clk),
        .rst_b        (rst_b),
        .flush        (w_take_branch),
        .push         (w_push),
        .push_data    (mem_rdata),
        .push_pc      (r_fa),
        .pop          (w_cons),
        .ir_valid     (w_ir_valid),
        .ir_data      (instruction),
        .ir_pc        (pc),
        .pb_valid     (w_pb_valid),
        .pb_valid_nxt (w_pb_valid_nxt)
    );

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign instr_valid = w_ir_valid;
    assign imm         = {{(16-IMM_W){1'b0}}, instruction[IMM_W-1:0]};

    logic w_unused;
    assign w_unused = w_pb_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_unit                                                              |
// | Self-checking bench: program-order reference model plus directed scenarios.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    logic        mem_req;
    logic [9:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        instr_valid;
    logic        cu_ready = 1'b0;
    logic [15:0] instruction;
    logic [15:0] imm;
    logic [9:0]  pc;
    logic        branch = 1'b0;
    logic [9:0]  branch_target = '0;

    int checks = 0;
    int failures = 0;

    int mem_mode = 0;
    int lat_mode = 0;
    int wait_cnt = 0;
    int cur_lat = 0;
    logic force_ack = 1'b0;

    fetch_unit dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .instr_valid   (instr_valid),
        .cu_ready      (cu_ready),
        .instruction   (instruction),
        .imm           (imm),
        .pc            (pc),
        .branch        (branch),
        .branch_target (branch_target)
    );

    always #5 clk = ~clk;

    // Program image: mode 0 is 16'h0400 + address, mode 1 a scrambled image.
    function automatic logic [15:0] mem_fn(input int mode, input logic [9:0] a);
        if (mode == 0) return 16'h0400 + {6'b0, a};
        return {a[6:0], a[9:1]} ^ 16'hC3A5;
    endfunction

    // Instruction memory with per-request latency; ack only while requested.
    assign mem_ack   = force_ack | (mem_req && (wait_cnt >= cur_lat));
    assign mem_rdata = force_ack ? 16'hDEAD : mem_fn(mem_mode, mem_addr);

    always @(posedge clk) begin
        if (!mem_req || mem_ack) begin
            wait_cnt <= 0;
            cur_lat  <= (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words must appear in program order from RESET_PC,
    // advancing by one per consume or jumping to the target on a taken branch.
    logic [9:0] exp_pc = '0;
    logic       rst_seen = 1'b0;
    logic       pend = 1'b0;
    logic [9:0] pend_addr = '0;
    int         starve = 0;

    always @(negedge clk) begin
        if (rst_b) begin
            exp_pc   = 10'd0;
            rst_seen = 1'b1;
            pend     = 1'b0;
            starve   = 0;
        end else begin
            if (rst_seen) begin
                chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
                chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
                chk("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
                chk("rst_pc", {22'b0, pc}, 32'd0);
                chk("rst_instruction", {16'b0, instruction}, 32'd0);
                rst_seen = 1'b0;
            end
            if (instr_valid) begin
                chk("model_pc", {22'b0, pc}, {22'b0, exp_pc});
                chk("model_instruction", {16'b0, instruction}, {16'b0, mem_fn(mem_mode, exp_pc)});
                chk("model_imm", {16'b0, imm}, {23'b0, mem_fn(mem_mode, exp_pc) & 16'h01FF});
                starve = 0;
            end else begin
                starve++;
                if (starve > 20) begin
                    checks++;
                    failures++;
                    $display("FAIL starve_timeout actual=%0d expected<=20 at %0t", starve, $time);
                    starve = 0;
                end
            end
            if (pend) begin
                chk("req_held", {31'b0, mem_req}, 32'd1);
                chk("addr_held", {22'b0, mem_addr}, {22'b0, pend_addr});
            end
            pend      = mem_req && !mem_ack;
            pend_addr = mem_addr;
            if (instr_valid && cu_ready)
                exp_pc = branch ? branch_target : exp_pc + 10'd1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat, input logic rdy);
        rst_b    = 1'b1;
        cu_ready = rdy;
        branch   = 1'b0;
        lat_mode = lat;
        step();
        step();
        rst_b = 1'b0;
    endtask

    // Wait (bounded) for a presented word, check its pc, then let it be consumed.
    task automatic next_word(input string name, input logic [9:0] want);
        for (int i = 0; i < 12 && !instr_valid; i++) step();
        chk({name, "_valid"}, {31'b0, instr_valid}, 32'd1);
        chk(name, {22'b0, pc}, {22'b0, want});
        step();
    endtask

    initial begin
        // Streaming after reset with a combinational memory.
        do_reset(0, 1'b1);
        chk("idle_req", {31'b0, mem_req}, 32'd0);
        step();
        chk("first_req", {31'b0, mem_req}, 32'd1);
        chk("first_addr", {22'b0, mem_addr}, 32'd0);
        chk("first_valid_low", {31'b0, instr_valid}, 32'd0);
        step();
        chk("first_valid", {31'b0, instr_valid}, 32'd1);
        chk("first_pc", {22'b0, pc}, 32'd0);
        chk("first_instr", {16'b0, instruction}, 32'h0400);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("stream_pc", {22'b0, pc}, i);
            chk("stream_instr", {16'b0, instruction}, 32'h0400 + i);
            chk("stream_addr", {22'b0, mem_addr}, i + 1);
        end

        // Stall: IR holds pc 0, PB fills with 1, request drops.
        do_reset(0, 1'b0);
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", {22'b0, pc}, 32'd0);
            chk("stall_req", {31'b0, mem_req}, 32'd0);
        end
        cu_ready = 1'b1;
        step();
        chk("release_pc", {22'b0, pc}, 32'd1);
        chk("release_instr", {16'b0, instruction}, 32'h0401);
        chk("release_addr", {22'b0, mem_addr}, 32'd2);

        // Branch with IR=1 and PB=2 both discarded.
        cu_ready = 1'b0;
        step();
        chk("pb2_req", {31'b0, mem_req}, 32'd0);
        cu_ready      = 1'b1;
        branch        = 1'b1;
        branch_target = 10'h200;
        step();
        branch = 1'b0;
        chk("br_bubble", {31'b0, instr_valid}, 32'd0);
        chk("br_addr", {22'b0, mem_addr}, 32'h200);
        step();
        chk("br_valid", {31'b0, instr_valid}, 32'd1);
        chk("br_pc", {22'b0, pc}, 32'h200);
        chk("br_instr", {16'b0, instruction}, 32'h0600);

        // Slow memory: branch while a request is pending goes through SQUASH.
        do_reset(2, 1'b1);
        for (int i = 0; i < 12 && !instr_valid; i++) step();
        chk("slow_pc", {22'b0, pc}, 32'd0);
        branch        = 1'b1;
        branch_target = 10'h050;
        step();
        branch = 1'b0;
        chk("sq_req", {31'b0, mem_req}, 32'd1);
        chk("sq_addr", {22'b0, mem_addr}, 32'd1);
        for (int i = 0; i < 10 && mem_addr == 10'd1; i++) begin
            chk("sq_no_valid", {31'b0, instr_valid}, 32'd0);
            step();
        end
        chk("sq_target_addr", {22'b0, mem_addr}, 32'h050);
        lat_mode = 0;
        next_word("sq_pc", 10'h050);

        // Sequential wrap 1023 -> 0.
        for (int i = 0; i < 12 && !instr_valid; i++) step();
        branch        = 1'b1;
        branch_target = 10'h3FE;
        step();
        branch = 1'b0;
        next_word("wrap_3fe", 10'h3FE);
        next_word("wrap_3ff", 10'h3FF);
        next_word("wrap_000", 10'h000);

        // Reset mid-request with a late ack while the request is low.
        do_reset(3, 1'b1);
        step();
        step();
        rst_b     = 1'b1;
        force_ack = 1'b1;
        step();
        chk("rr_req", {31'b0, mem_req}, 32'd0);
        step();
        rst_b = 1'b0;
        step();
        force_ack = 1'b0;
        next_word("rr_first_pc", 10'd0);

        // Randomised traffic against the model.
        mem_mode = 1;
        do_reset(-1, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            cu_ready      = ($urandom_range(0, 9) < 7);
            branch        = ($urandom_range(0, 9) < 2);
            branch_target = 10'($urandom);
            rst_b         = ($urandom_range(0, 299) == 0);
            step();
        end
        rst_b = 1'b0;
        branch = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
